// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard receiver with Set-2 scancode to ASCII decode.
// Optional feature macro: PS2_CAPSLOCK_EN adds a caps-lock toggle on scancode 8'h58.
module ps2_ascii_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_pressed,
    output logic       kbd_data_ready,
    output logic       frame_err
);

    localparam int unsigned          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s, ps2_dat_s, fall_c, tmo_hit_c;

    rx_state_e              state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_bad_q, par_bad_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   byte_valid_c, rx_err_c;

    logic [7:0]             key_q, key_d;
    logic                   rdy_q, rdy_d, err_q;
    logic                   shift_q, shift_d, brk_q, brk_d, ext_q, ext_d;
    logic                   upper_c;
    logic [9:0]             map_c;
    logic [7:0]             ascii_c;
`ifdef PS2_CAPSLOCK_EN
    logic                   caps_q, caps_d, caps_held_q, caps_held_d;
`endif

    // Synchronise the raw PS/2 lines; reset to the idle-high level so no false edge appears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall_c    = clk_prev_q & ~ps2_clk_s;
    assign tmo_hit_c = (state_q != S_IDLE) && !fall_c && (tmo_q >= TMO_LAST);

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // RX next state: one step per PS/2 falling edge, abort to IDLE on timeout
    always_comb begin
        state_d = state_q;
        if (tmo_hit_c) begin
            state_d = S_IDLE;
        end else if (fall_c) begin
            case (state_q)
                S_IDLE:   if (!ps2_dat_s) state_d = S_DATA;
                S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // RX outputs: completed byte strobe and framing error strobe
    always_comb begin
        byte_valid_c = 1'b0;
        rx_err_c     = 1'b0;
        if (tmo_hit_c) begin
            rx_err_c = 1'b1;
        end else if (fall_c) begin
            case (state_q)
                S_IDLE: rx_err_c = ps2_dat_s;
                S_STOP: begin
                    if (ps2_dat_s && !par_bad_q) byte_valid_c = 1'b1;
                    else                         rx_err_c     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RX datapath: shift register, bit count, parity flag, saturating timeout counter
    always_comb begin
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        tmo_d     = tmo_q;
        if (state_q == S_IDLE || fall_c) tmo_d = '0;
        else if (tmo_q < TMO_LAST)       tmo_d = tmo_q + TMO_W'(1);
        if (fall_c) begin
            case (state_q)
                S_IDLE: begin
                    bitcnt_d  = 3'd0;
                    par_bad_d = 1'b0;
                end
                S_DATA: begin
                    shreg_d  = {ps2_dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                S_PARITY: par_bad_d = ~(^shreg_q ^ ps2_dat_s);
                default: ;
            endcase
        end
    end

    // RX datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            par_bad_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            tmo_q     <= tmo_d;
        end
    end

    // Set-2 code lookup: {mapped, is_letter, lower-case ASCII}
    function automatic logic [9:0] map_code(input logic [7:0] code);
        case (code)
            8'h1C: map_code = {2'b11, 8'h61}; 8'h32: map_code = {2'b11, 8'h62};
            8'h21: map_code = {2'b11, 8'h63}; 8'h23: map_code = {2'b11, 8'h64};
            8'h24: map_code = {2'b11, 8'h65}; 8'h2B: map_code = {2'b11, 8'h66};
            8'h34: map_code = {2'b11, 8'h67}; 8'h33: map_code = {2'b11, 8'h68};
            8'h43: map_code = {2'b11, 8'h69}; 8'h3B: map_code = {2'b11, 8'h6A};
            8'h42: map_code = {2'b11, 8'h6B}; 8'h4B: map_code = {2'b11, 8'h6C};
            8'h3A: map_code = {2'b11, 8'h6D}; 8'h31: map_code = {2'b11, 8'h6E};
            8'h44: map_code = {2'b11, 8'h6F}; 8'h4D: map_code = {2'b11, 8'h70};
            8'h15: map_code = {2'b11, 8'h71}; 8'h2D: map_code = {2'b11, 8'h72};
            8'h1B: map_code = {2'b11, 8'h73}; 8'h2C: map_code = {2'b11, 8'h74};
            8'h3C: map_code = {2'b11, 8'h75}; 8'h2A: map_code = {2'b11, 8'h76};
            8'h1D: map_code = {2'b11, 8'h77}; 8'h22: map_code = {2'b11, 8'h78};
            8'h35: map_code = {2'b11, 8'h79}; 8'h1A: map_code = {2'b11, 8'h7A};
            8'h45: map_code = {2'b10, 8'h30}; 8'h16: map_code = {2'b10, 8'h31};
            8'h1E: map_code = {2'b10, 8'h32}; 8'h26: map_code = {2'b10, 8'h33};
            8'h25: map_code = {2'b10, 8'h34}; 8'h2E: map_code = {2'b10, 8'h35};
            8'h36: map_code = {2'b10, 8'h36}; 8'h3D: map_code = {2'b10, 8'h37};
            8'h3E: map_code = {2'b10, 8'h38}; 8'h46: map_code = {2'b10, 8'h39};
            8'h29: map_code = {2'b10, 8'h20}; 8'h5A: map_code = {2'b10, 8'h0D};
            8'h66: map_code = {2'b10, 8'h08};
            default: map_code = 10'h000;
        endcase
    endfunction

`ifdef PS2_CAPSLOCK_EN
    assign upper_c = shift_q ^ caps_q;
`else
    assign upper_c = shift_q;
`endif
    assign map_c   = map_code(shreg_q);
    assign ascii_c = (map_c[8] && upper_c) ? (map_c[7:0] - 8'h20) : map_c[7:0];

    // Decode prefix/modifier bytes and update the held-key register on each valid byte
    always_comb begin
        key_d   = key_q;
        rdy_d   = 1'b0;
        shift_d = shift_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
`ifdef PS2_CAPSLOCK_EN
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
`endif
        if (byte_valid_c) begin
            if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else begin
                brk_d = 1'b0;
                if (shreg_q == 8'h12 || shreg_q == 8'h59) begin
                    shift_d = ~brk_q;
`ifdef PS2_CAPSLOCK_EN
                end else if (shreg_q == 8'h58) begin
                    if (brk_q) begin
                        caps_held_d = 1'b0;
                    end else if (!caps_held_q) begin
                        caps_d      = ~caps_q;
                        caps_held_d = 1'b1;
                    end
`endif
                end else if (map_c[9]) begin
                    if (brk_q) begin
                        if (ascii_c == key_q) key_d = 8'h00;
                    end else begin
                        key_d = ascii_c;
                        rdy_d = 1'b1;
                    end
                end
            end
        end
    end

    // Decoder and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q   <= 8'h00;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            shift_q <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
`ifdef PS2_CAPSLOCK_EN
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
`endif
        end else begin
            key_q   <= key_d;
            rdy_q   <= rdy_d;
            err_q   <= rx_err_c;
            shift_q <= shift_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
`ifdef PS2_CAPSLOCK_EN
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
`endif
        end
    end

    assign key_pressed    = key_q;
    assign kbd_data_ready = rdy_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder; honours PS2_CAPSLOCK_EN when defined.
module tb_ps2_ascii_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_pressed;
    logic       kbd_data_ready;
    logic       frame_err;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         rdy_total = 0;
    int         err_total = 0;
    logic [7:0] rdy_val = 8'h00;
    int         r0, e0;

    ps2_ascii_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .key_pressed    (key_pressed),
        .kbd_data_ready (kbd_data_ready),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles of each strobe and records key value seen with ready
    always @(negedge clk) begin
        if (kbd_data_ready) begin
            rdy_total = rdy_total + 1;
            rdy_val   = key_pressed;
        end
        if (frame_err) err_total = err_total + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        r0 = rdy_total;
        e0 = err_total;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(1'b1);
        settle();
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        check_val("rst_key", 32'(key_pressed), 32'h00);
        check_val("rst_rdy", 32'(kbd_data_ready), 32'h0);
        check_val("rst_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        settle();

        // single make 'e'
        mark();
        send(8'h24);
        check_val("t1_key", 32'(key_pressed), 32'h65);
        check_val("t1_pulses", 32'(rdy_total - r0), 32'd1);
        check_val("t1_rdy_val", 32'(rdy_val), 32'h65);
        check_val("t1_no_err", 32'(err_total - e0), 32'd0);

        // shifted 'D' then breaks
        mark();
        send(8'h12);
        send(8'h23);
        check_val("t2_key_D", 32'(key_pressed), 32'h44);
        check_val("t2_pulses", 32'(rdy_total - r0), 32'd1);
        mark();
        send(8'hF0);
        send(8'h23);
        check_val("t2_brk_key", 32'(key_pressed), 32'h00);
        send(8'hF0);
        send(8'h12);
        check_val("t2_brk_shift", 32'(key_pressed), 32'h00);
        check_val("t2_brk_pulses", 32'(rdy_total - r0), 32'd0);
        send(8'h24);
        check_val("t2_shift_off", 32'(key_pressed), 32'h65);

        // break of a different key and an unmapped make leave the held key alone
        mark();
        send(8'hF0);
        send(8'h23);
        check_val("brk_other", 32'(key_pressed), 32'h65);
        send(8'h05);
        check_val("unmapped", 32'(key_pressed), 32'h65);
        check_val("unmapped_pulses", 32'(rdy_total - r0), 32'd0);

        // parity error
        send(8'hF0);
        send(8'h24);
        check_val("t3_pre_key", 32'(key_pressed), 32'h00);
        mark();
        send_frame(8'h24, 1'b1);
        check_val("t3_err", 32'(err_total - e0), 32'd1);
        check_val("t3_rdy", 32'(rdy_total - r0), 32'd0);
        check_val("t3_key", 32'(key_pressed), 32'h00);

        // start bit sampled high in IDLE
        mark();
        ps2_bit(1'b1);
        settle();
        check_val("bad_start_err", 32'(err_total - e0), 32'd1);

        // timeout mid-frame, then a clean frame
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (60000) @(negedge clk);
        settle();
        check_val("t4_tmo_err", 32'(err_total - e0), 32'd1);
        mark();
        send(8'h2D);
        check_val("t4_key_r", 32'(key_pressed), 32'h72);
        check_val("t4_pulses", 32'(rdy_total - r0), 32'd1);
        check_val("t4_no_err", 32'(err_total - e0), 32'd0);

        // extended code ignored, typematic repeats
        mark();
        send(8'hE0);
        send(8'h74);
        check_val("t5_ext_key", 32'(key_pressed), 32'h72);
        check_val("t5_ext_rdy", 32'(rdy_total - r0), 32'd0);
        send(8'h24);
        send(8'h24);
        send(8'h24);
        check_val("t5_rep_key", 32'(key_pressed), 32'h65);
        check_val("t5_rep_pulses", 32'(rdy_total - r0), 32'd3);

        // reset mid-DATA with 'E' held
        send(8'h12);
        send(8'h24);
        check_val("t6_pre_key", 32'(key_pressed), 32'h45);
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        check_val("t6_rst_key", 32'(key_pressed), 32'h00);
        check_val("t6_rst_rdy", 32'(rdy_total - r0), 32'd0);
        check_val("t6_rst_err", 32'(err_total - e0), 32'd0);
        send(8'h24);
        check_val("t6_shift_clr", 32'(key_pressed), 32'h65);

`ifdef PS2_CAPSLOCK_EN
        // caps lock toggles case; repeat of 58 without break is ignored
        send(8'hF0);
        send(8'h24);
        mark();
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        send(8'h24);
        check_val("caps_on_key", 32'(key_pressed), 32'h45);
        check_val("caps_on_pulses", 32'(rdy_total - r0), 32'd1);
        send(8'h58);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        send(8'h24);
        check_val("caps_off_key", 32'(key_pressed), 32'h65);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
